// File: rtl/mac_pe.sv
// Registered multiply-accumulate PE for the systolic array: forwards weight and
// feature-map samples one stage and accumulates their product onto the upstream sum.
module mac_pe #(
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             w_prefetch_in,
  input  logic                             w_enable_in,
  input  logic                             ifmap_start_in,
  input  logic                             ifmap_enable_in,
  input  logic                             MAC_valid_in,
  input  logic signed [W_BITWIDTH-1:0]     w_data_in,
  input  logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_in,
  input  logic signed [OFMAP_BITWIDTH-1:0] MAC_data_in,
  output logic                             ifmap_enable_out,
  output logic                             MAC_valid_out,
  output logic signed [W_BITWIDTH-1:0]     w_data_out,
  output logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_out,
  output logic signed [OFMAP_BITWIDTH-1:0] MAC_data_out
);

  localparam int PROD_BITWIDTH = W_BITWIDTH + IFMAP_BITWIDTH;

  logic signed [PROD_BITWIDTH-1:0]  product;
  logic signed [OFMAP_BITWIDTH-1:0] product_ext;

  // Marker inputs are reserved for a future revision and drive nothing.
  logic unused_markers;
  assign unused_markers = w_prefetch_in ^ w_enable_in ^ ifmap_start_in;

  // Multiply uses the registered operands, giving the 2-cycle product latency.
  always_comb begin
    product     = w_data_out * ifmap_data_out;
    product_ext = OFMAP_BITWIDTH'(product);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_data_out       <= '0;
      ifmap_data_out   <= '0;
      ifmap_enable_out <= 1'b0;
      MAC_valid_out    <= 1'b0;
      MAC_data_out     <= '0;
    end else begin
      w_data_out       <= w_data_in;
      ifmap_data_out   <= ifmap_data_in;
      ifmap_enable_out <= ifmap_enable_in;
      MAC_valid_out    <= MAC_valid_in;
      MAC_data_out     <= product_ext + MAC_data_in;
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// Directed self-checking bench for mac_pe with hand-computed expectations;
// marker inputs are randomised throughout and must never matter.
module tb_mac_pe;

  logic               clk = 1'b0;
  logic               rstn;
  logic               w_prefetch_in, w_enable_in, ifmap_start_in;
  logic               ifmap_enable_in, MAC_valid_in;
  logic signed [7:0]  w_data_in;
  logic signed [15:0] ifmap_data_in;
  logic signed [31:0] MAC_data_in;
  logic               ifmap_enable_out, MAC_valid_out;
  logic signed [7:0]  w_data_out;
  logic signed [15:0] ifmap_data_out;
  logic signed [31:0] MAC_data_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_pe #(
    .IFMAP_BITWIDTH(16),
    .W_BITWIDTH    (8),
    .OFMAP_BITWIDTH(32)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .w_prefetch_in   (w_prefetch_in),
    .w_enable_in     (w_enable_in),
    .ifmap_start_in  (ifmap_start_in),
    .ifmap_enable_in (ifmap_enable_in),
    .MAC_valid_in    (MAC_valid_in),
    .w_data_in       (w_data_in),
    .ifmap_data_in   (ifmap_data_in),
    .MAC_data_in     (MAC_data_in),
    .ifmap_enable_out(ifmap_enable_out),
    .MAC_valid_out   (MAC_valid_out),
    .w_data_out      (w_data_out),
    .ifmap_data_out  (ifmap_data_out),
    .MAC_data_out    (MAC_data_out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Apply inputs, clock one edge, sample #1 later. tie=1 feeds MAC_data_out back.
  task automatic cycle(input logic r, input logic signed [7:0] w, input logic signed [15:0] i,
                       input logic en, input logic val, input logic tie,
                       input logic signed [31:0] mac);
    rstn            = r;
    w_data_in       = w;
    ifmap_data_in   = i;
    ifmap_enable_in = en;
    MAC_valid_in    = val;
    MAC_data_in     = tie ? MAC_data_out : mac;
    w_prefetch_in   = 1'($urandom_range(1));
    w_enable_in     = 1'($urandom_range(1));
    ifmap_start_in  = 1'($urandom_range(1));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic signed [7:0] w,
                            input logic signed [15:0] i, input logic en,
                            input logic val, input logic signed [31:0] mac);
    check({tag, ".w"},   32'(w_data_out), 32'(w));
    check({tag, ".if"},  32'(ifmap_data_out), 32'(i));
    check({tag, ".en"},  32'(ifmap_enable_out), 32'(en));
    check({tag, ".val"}, 32'(MAC_valid_out), 32'(val));
    check({tag, ".mac"}, MAC_data_out, mac);
  endtask

  initial begin
    rstn = 1'b0; w_data_in = '0; ifmap_data_in = '0; MAC_data_in = '0;
    ifmap_enable_in = 1'b0; MAC_valid_in = 1'b0;
    w_prefetch_in = 1'b0; w_enable_in = 1'b0; ifmap_start_in = 1'b0;
    #2;

    // Reset with busy inputs
    cycle(1'b0, 8'sd55, 16'sd1234, 1'b1, 1'b1, 1'b0, 32'sd999);
    cycle(1'b0, -8'sd7, -16'sd300, 1'b1, 1'b1, 1'b0, -32'sd5);
    expect_out("reset", 0, 0, 1'b0, 1'b0, 0);

    // First edge after release: registers held 0, so MAC_data_out = MAC_data_in = 0
    cycle(1'b1, -8'sd128, 16'sd1, 1'b1, 1'b1, 1'b0, 32'sd0);
    expect_out("e1", -8'sd128, 16'sd1, 1'b1, 1'b1, 0);
    // Accumulation loop with feedback
    cycle(1'b1, -8'sd105, -16'sd2, 1'b0, 1'b1, 1'b1, 0);
    expect_out("e2", -8'sd105, -16'sd2, 1'b0, 1'b1, -32'sd128);
    cycle(1'b1, -8'sd82, 16'sd4, 1'b1, 1'b0, 1'b1, 0);
    expect_out("e3", -8'sd82, 16'sd4, 1'b1, 1'b0, 32'sd82);
    cycle(1'b1, -8'sd59, -16'sd8, 1'b0, 1'b0, 1'b1, 0);
    expect_out("e4", -8'sd59, -16'sd8, 1'b0, 1'b0, -32'sd246);
    cycle(1'b1, 8'sd0, 16'sd0, 1'b1, 1'b1, 1'b1, 0);
    expect_out("e5", 0, 0, 1'b1, 1'b1, 32'sd226);

    // Mid-stream reset discards the running sum
    cycle(1'b0, 8'sd100, 16'sd100, 1'b1, 1'b1, 1'b1, 0);
    expect_out("midrst", 0, 0, 1'b0, 1'b0, 0);
    cycle(1'b1, -8'sd128, -16'sd32768, 1'b0, 1'b1, 1'b1, 0);
    expect_out("restart", -8'sd128, -16'sd32768, 1'b0, 1'b1, 0);

    // Sign extremes
    cycle(1'b1, 8'sd127, 16'sd32767, 1'b1, 1'b0, 1'b0, 32'sd0);
    expect_out("negmax", 8'sd127, 16'sd32767, 1'b1, 1'b0, 32'sd4194304);
    cycle(1'b1, 8'sd0, 16'sd0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF);
    expect_out("wrap", 0, 0, 1'b0, 1'b0, 32'h803F_7F80);

    // Plain upstream pass-through term
    cycle(1'b1, 8'sd3, -16'sd5, 1'b0, 1'b1, 1'b0, 32'sd1000);
    expect_out("pass", 8'sd3, -16'sd5, 1'b0, 1'b1, 32'sd1000);
    cycle(1'b1, 8'sd0, 16'sd0, 1'b0, 1'b0, 1'b0, -32'sd20);
    expect_out("prod", 0, 0, 1'b0, 1'b0, -32'sd35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_pe.md
# mac_pe

Registered multiply-accumulate processing element for the systolic array. Each cycle it forwards the incoming weight and feature-map samples to its neighbours through one register stage. It multiplies the registered weight and feature-map values, adds the partial sum arriving from the upstream PE, and registers the result as its own partial-sum output. Enable and valid flags travel alongside the data through matching one-cycle registers.

## Interface
- IFMAP_BITWIDTH, 16: signed feature-map sample width
- W_BITWIDTH, 8: signed weight width
- OFMAP_BITWIDTH, 32: signed partial-sum width; must be ≥ IFMAP_BITWIDTH+W_BITWIDTH
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- w_prefetch_in  in  1  weight-prefetch marker; no effect on datapath in this revision
- w_enable_in  in  1  weight-enable marker; no effect on datapath in this revision
- ifmap_start_in  in  1  feature-map start marker; no effect on datapath in this revision
- ifmap_enable_in  in  1  feature-map enable, forwarded
- MAC_valid_in  in  1  upstream partial-sum valid, forwarded
- w_data_in  in  W_BITWIDTH  signed weight from neighbour
- ifmap_data_in  in  IFMAP_BITWIDTH  signed feature-map sample from neighbour
- MAC_data_in  in  OFMAP_BITWIDTH  signed upstream partial sum
- ifmap_enable_out  out  1  registered ifmap_enable_in
- MAC_valid_out  out  1  registered MAC_valid_in
- w_data_out  out  W_BITWIDTH  registered weight
- ifmap_data_out  out  IFMAP_BITWIDTH  registered feature-map sample
- MAC_data_out  out  OFMAP_BITWIDTH  registered partial sum

## Operation
- All outputs are direct register outputs. There is no combinational input-to-output path.
- On each rising edge with rstn=1:
  - w_data_out ← w_data_in
  - ifmap_data_out ← ifmap_data_in
  - ifmap_enable_out ← ifmap_enable_in
  - MAC_valid_out ← MAC_valid_in
  - MAC_data_out ← sext(w_data_out × ifmap_data_out) + MAC_data_in
- Arithmetic:
  - The product is a signed W_BITWIDTH × IFMAP_BITWIDTH multiply yielding a 24-bit result at the defaults.
  - The product is sign-extended to OFMAP_BITWIDTH.
  - The addition wraps modulo 2^OFMAP_BITWIDTH, with no saturation or overflow flag.
- The multiply uses the current register contents of w_data_out and ifmap_data_out, i.e. the values captured one edge earlier. It does not use the live inputs.
- The datapath updates every cycle, independent of any enable or valid flag. Qualifying results is the job of the consumer using MAC_valid_out.
- The marker inputs w_prefetch_in, w_enable_in and ifmap_start_in are sampled by nothing. They must not alter any output.
- There is no state machine.

## Timing
- Reset: on a rising edge with rstn=0, every output register becomes 0.
  - This includes both flags and all three data outputs.
  - Reset overrides any input activity on the same edge.
  - Reset mid-stream discards the in-flight partial sum.
- Latency:
  - Weight, feature-map and both flags: 1 cycle.
  - Product term: 2 cycles from w_data_in/ifmap_data_in to MAC_data_out.
  - MAC_data_in term: 1 cycle to MAC_data_out.
- First edge after reset release: MAC_data_out = 0 + MAC_data_in, because both data registers hold 0.
- Accumulating chain: when MAC_data_in is tied to MAC_data_out and inputs change every cycle, MAC_data_out at edge t = Σ over k ≤ t−2 of w[k]·ifmap[k].

## Test plan
- Reset:
  - Stimulus: hold rstn=0 for ≥1 edge with nonzero inputs.
  - Required: all outputs are 0 one edge later.
  - Repeat mid-stream: after a reset pulse the outputs are 0 and accumulation restarts from 0.
- Forwarding:
  - Stimulus: drive w = −128 then −105, and ifmap = 1 then −2.
  - Required: w_data_out and ifmap_data_out show each value exactly one edge later.
  - Required: ifmap_enable_out and MAC_valid_out track their inputs with a 1-cycle delay.
- Single product:
  - Stimulus: w=−128, ifmap=1, MAC_data_in=0.
  - Required: MAC_data_out = −128 two edges after the inputs are applied.
- Accumulation loop:
  - Stimulus: tie MAC_data_in to MAC_data_out; apply w sequence −128, −105, −82, …, each value +23, with ifmap 1, −2, 4, −8, ….
  - Required: MAC_data_out = −128, then −128+210=82, then 82−328=−246, appearing in order on successive edges after the 2-cycle latency.
- Sign extremes:
  - Stimulus: w=−128, ifmap=−32768, MAC_data_in=0.
  - Required: MAC_data_out = 4194304.
  - Stimulus: w=127, ifmap=32767, MAC_data_in=0x7FFFFFFF.
  - Required: the sum wraps modulo 2^32.
- Marker independence:
  - Stimulus: toggle w_prefetch_in, w_enable_in and ifmap_start_in arbitrarily during a stream.
  - Required: all outputs are identical to a run with those markers held at 0.
